// File: rtl/axi_lite_regfile_slv.sv
// AXI4-Lite register-file subordinate with independent write (AW/W/B) and read (AR/R) FSMs.
// The NumRegs x DataWidth register bank is also exported flat on reg_o.
package axi_lite_regfile_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;
  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;
  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_lite_regfile_slv #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          NumRegs    = 16,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter type                  axi_req_t  = axi_lite_regfile_pkg::axi_req_t,
  parameter type                  axi_resp_t = axi_lite_regfile_pkg::axi_resp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  axi_req_t                       slv_req_i,
  output axi_resp_t                      slv_resp_o,
  output logic [NumRegs*DataWidth-1:0]   reg_o
);
  localparam int unsigned          StrbWidth  = DataWidth / 8;
  localparam int unsigned          OffWidth   = $clog2(StrbWidth);
  localparam int unsigned          IdxWidth   = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [AddrWidth-1:0] NumRegsA   = AddrWidth'(NumRegs);
  localparam logic [1:0]           RespOkay   = 2'b00;
  localparam logic [1:0]           RespSlvErr = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic addr_hit(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] word;
    word = (addr - BaseAddr) >> OffWidth;
    return (addr >= BaseAddr) && (word < NumRegsA);
  endfunction

  function automatic logic [IdxWidth-1:0] addr_idx(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] word;
    word = (addr - BaseAddr) >> OffWidth;
    return word[IdxWidth-1:0];
  endfunction

  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  logic                   rdy_en_q;
  logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AddrWidth-1:0]   aw_addr_q, aw_addr_d;
  logic [DataWidth-1:0]   w_data_q, w_data_d;
  logic [StrbWidth-1:0]   w_strb_q, w_strb_d;
  logic [1:0]             b_resp_q, b_resp_d;
  logic [DataWidth-1:0]   r_data_q, r_data_d;
  logic [1:0]             r_resp_q, r_resp_d;
  logic [DataWidth-1:0]   regs_q [NumRegs];
  logic [DataWidth-1:0]   regs_d [NumRegs];
  logic                   aw_ready, w_ready, ar_ready;
  logic [AddrWidth-1:0]   wr_addr;
  logic [DataWidth-1:0]   wr_data;
  logic [StrbWidth-1:0]   wr_strb;
  logic                   unused_prot;

  assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

  // Write FSM: the later of AW/W may arrive on the commit edge, so bypass the capture regs.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_resp_d  = b_resp_q;
    regs_d    = regs_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    wr_addr   = aw_addr_q;
    wr_data   = w_data_q;
    wr_strb   = w_strb_q;
    unique case (w_state_q)
      W_COLLECT: begin
        aw_ready = rdy_en_q && !aw_held_q;
        w_ready  = rdy_en_q && !w_held_q;
        if (slv_req_i.aw_valid && aw_ready) begin
          aw_held_d = 1'b1;
          aw_addr_d = slv_req_i.aw.addr;
          wr_addr   = slv_req_i.aw.addr;
        end
        if (slv_req_i.w_valid && w_ready) begin
          w_held_d = 1'b1;
          w_data_d = slv_req_i.w.data;
          w_strb_d = slv_req_i.w.strb;
          wr_data  = slv_req_i.w.data;
          wr_strb  = slv_req_i.w.strb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_RESP;
          if (addr_hit(wr_addr)) begin
            b_resp_d = RespOkay;
            for (int i = 0; i < StrbWidth; i++) begin
              if (wr_strb[i]) regs_d[addr_idx(wr_addr)][8*i +: 8] = wr_data[8*i +: 8];
            end
          end else begin
            b_resp_d = RespSlvErr;
          end
        end
      end
      W_RESP: begin
        if (slv_req_i.b_ready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Read FSM samples regs_q, so a same-edge write to the same register returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    ar_ready  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = rdy_en_q;
        if (slv_req_i.ar_valid && ar_ready) begin
          r_state_d = R_RESP;
          if (addr_hit(slv_req_i.ar.addr)) begin
            r_data_d = regs_q[addr_idx(slv_req_i.ar.addr)];
            r_resp_d = RespOkay;
          end else begin
            r_data_d = '0;
            r_resp_d = RespSlvErr;
          end
        end
      end
      R_RESP: begin
        if (slv_req_i.r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_COLLECT;
      r_state_q <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      regs_q    <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = (w_state_q == W_RESP);
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = (r_state_q == R_RESP);
    slv_resp_o.r.resp   = r_resp_q;
    slv_resp_o.r.data   = r_data_q;
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_reg_o
    assign reg_o[k*DataWidth +: DataWidth] = regs_q[k];
  end

  // Handshake rule: a valid raised without its ready must stay raised until accepted.
  assert property (@(posedge clk_i) (BaseAddr[OffWidth-1:0] == '0) && (NumRegs >= 1)
                   && ((DataWidth == 32) || (DataWidth == 64)))
    else $error("axi_lite_regfile_slv: illegal parameterisation");
  assert property (@(posedge clk_i) disable iff (rst_i)
                   slv_req_i.aw_valid && !slv_resp_o.aw_ready |=> slv_req_i.aw_valid)
    else $error("aw_valid dropped before aw_ready");
  assert property (@(posedge clk_i) disable iff (rst_i)
                   slv_req_i.w_valid && !slv_resp_o.w_ready |=> slv_req_i.w_valid)
    else $error("w_valid dropped before w_ready");
  assert property (@(posedge clk_i) disable iff (rst_i)
                   slv_req_i.ar_valid && !slv_resp_o.ar_ready |=> slv_req_i.ar_valid)
    else $error("ar_valid dropped before ar_ready");
endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
// Directed plus randomised bench for axi_lite_regfile_slv with a scoreboard of B/R responses
// and a register-file model compared against reg_o.
module tb_axi_lite_regfile_slv;
  import axi_lite_regfile_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned NR     = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic              clk;
  logic              rst;
  axi_req_t          req;
  axi_resp_t         resp;
  logic [NR*DW-1:0]  reg_o;

  int                n_tests;
  int                n_fail;
  logic [1:0]        b_exp_q[$];
  logic [33:0]       r_exp_q[$];
  logic [31:0]       mdl [NR];

  axi_lite_regfile_slv #(
    .AddrWidth (32),
    .DataWidth (DW),
    .NumRegs   (NR),
    .BaseAddr  (BASE),
    .axi_req_t (axi_req_t),
    .axi_resp_t(axi_resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (req),
    .slv_resp_o(resp),
    .reg_o     (reg_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // model
  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(NR * 4));
  endfunction

  task automatic write_expect(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (in_range(a)) begin
      idx = int'((a - BASE) >> 2);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      b_exp_q.push_back(OKAY);
    end else begin
      b_exp_q.push_back(SLVERR);
    end
  endtask

  task automatic read_expect(input logic [31:0] a);
    if (in_range(a)) r_exp_q.push_back({OKAY, mdl[int'((a - BASE) >> 2)]});
    else             r_exp_q.push_back({SLVERR, 32'h0});
  endtask

  function automatic int regs_mismatch();
    int n = 0;
    for (int k = 0; k < NR; k++) if (reg_o[k*DW +: DW] !== mdl[k]) n++;
    return n;
  endfunction

  // drivers: every task starts and ends just after a falling edge
  task automatic drive_req(input string tag, input bit en_aw, input bit en_w, input bit en_ar,
                           input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input logic [31:0] ra);
    bit p_aw, p_w, p_ar, h_aw, h_w, h_ar;
    p_aw = en_aw; p_w = en_w; p_ar = en_ar;
    req.aw.addr = wa; req.aw.prot = 3'($urandom_range(0, 7));
    req.w.data  = wd; req.w.strb  = ws;
    req.ar.addr = ra; req.ar.prot = 3'($urandom_range(0, 7));
    req.aw_valid = en_aw; req.w_valid = en_w; req.ar_valid = en_ar;
    for (int t = 0; t < 20 && (p_aw || p_w || p_ar); t++) begin
      h_aw = p_aw && resp.aw_ready;
      h_w  = p_w  && resp.w_ready;
      h_ar = p_ar && resp.ar_ready;
      @(negedge clk);
      if (h_aw) begin p_aw = 1'b0; req.aw_valid = 1'b0; end
      if (h_w)  begin p_w  = 1'b0; req.w_valid  = 1'b0; end
      if (h_ar) begin p_ar = 1'b0; req.ar_valid = 1'b0; end
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    check({tag, "_hs_pending"}, 64'({p_aw, p_w, p_ar}), 0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    write_expect(a, d, s);
    drive_req(tag, 1'b1, 1'b1, 1'b0, a, d, s, '0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    read_expect(a);
    drive_req(tag, 1'b0, 1'b0, 1'b1, '0, '0, '0, a);
  endtask

  task automatic take_b(input int stall, input string tag);
    logic [1:0] exp;
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (resp.b_valid) seen = 1'b1; else @(negedge clk);
    end
    check({tag, "_bvalid"}, 64'(seen), 1);
    check({tag, "_bsb"}, 64'(b_exp_q.size() != 0), 1);
    if (seen && b_exp_q.size() != 0) begin
      exp = b_exp_q.pop_front();
      check({tag, "_bresp"}, 64'(resp.b.resp), 64'(exp));
      for (int t = 0; t < stall; t++) begin
        @(negedge clk);
        check({tag, "_bstall"}, 64'({resp.b_valid, resp.b.resp, resp.aw_ready, resp.w_ready}),
              64'({1'b1, exp, 2'b00}));
      end
      req.b_ready = 1'b1;
      @(negedge clk);
      req.b_ready = 1'b0;
      check({tag, "_bdone"}, 64'({resp.b_valid, resp.aw_ready, resp.w_ready}), 64'(3'b011));
    end
  endtask

  task automatic take_r(input int stall, input string tag);
    logic [33:0] exp;
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (resp.r_valid) seen = 1'b1; else @(negedge clk);
    end
    check({tag, "_rvalid"}, 64'(seen), 1);
    check({tag, "_rsb"}, 64'(r_exp_q.size() != 0), 1);
    if (seen && r_exp_q.size() != 0) begin
      exp = r_exp_q.pop_front();
      check({tag, "_rdata"}, 64'({resp.r.resp, resp.r.data}), 64'(exp));
      for (int t = 0; t < stall; t++) begin
        @(negedge clk);
        check({tag, "_rstall"}, 64'({resp.r_valid, resp.r.resp, resp.r.data, resp.ar_ready}),
              64'({1'b1, exp, 1'b0}));
      end
      req.r_ready = 1'b1;
      @(negedge clk);
      req.r_ready = 1'b0;
      check({tag, "_rdone"}, 64'({resp.r_valid, resp.ar_ready}), 64'(2'b01));
    end
  endtask

  logic [NR*DW-1:0] snap;
  logic [31:0]      ra;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    req     = '0;
    rst     = 1'b1;
    foreach (mdl[i]) mdl[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_flags", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid}), 0);
    check("rst_reg_o", 64'(regs_mismatch()), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'(3'b111));

    // reset mid-write discards the pending AW and clears registers
    wr("t1_pre", BASE + 32'd20, 32'h1234_5678, 4'hF);
    take_b(0, "t1_pre");
    check("t1_pre_reg5", 64'(reg_o[5*DW +: DW]), 64'h1234_5678);
    drive_req("t1_aw", 1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0, '0);
    check("t1_aw_held", 64'({resp.aw_ready, resp.w_ready}), 64'(2'b01));
    rst = 1'b1;
    @(negedge clk);
    check("t1_in_rst", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (mdl[i]) mdl[i] = '0;
    @(negedge clk);
    check("t1_after", 64'({resp.b_valid, resp.aw_ready, resp.w_ready}), 64'(3'b011));
    check("t1_reg_o", 64'(regs_mismatch()), 0);

    // AW then W three cycles later; response one cycle after the W handshake
    write_expect(BASE + 32'd8, 32'hDEAD_BEEF, 4'hF);
    drive_req("t2a_aw", 1'b1, 1'b0, 1'b0, BASE + 32'd8, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("t2a_wait", 64'({resp.b_valid, reg_o[2*DW +: DW]}), 0);
    drive_req("t2a_w", 1'b0, 1'b1, 1'b0, '0, 32'hDEAD_BEEF, 4'hF, '0);
    check("t2a_lat", 64'({resp.b_valid, resp.b.resp}), 64'({1'b1, OKAY}));
    check("t2a_reg2", 64'(reg_o[2*DW +: DW]), 64'hDEAD_BEEF);
    take_b(0, "t2a");

    // W before AW
    write_expect(BASE + 32'd16, 32'hDEAD_BEEF, 4'hF);
    drive_req("t2b_w", 1'b0, 1'b1, 1'b0, '0, 32'hDEAD_BEEF, 4'hF, '0);
    repeat (2) @(negedge clk);
    check("t2b_wait", 64'({resp.b_valid, resp.aw_ready, resp.w_ready}), 64'(3'b010));
    drive_req("t2b_aw", 1'b1, 1'b0, 1'b0, BASE + 32'd16, '0, '0, '0);
    check("t2b_lat", 64'({resp.b_valid, resp.b.resp}), 64'({1'b1, OKAY}));
    check("t2b_reg4", 64'(reg_o[4*DW +: DW]), 64'hDEAD_BEEF);
    take_b(0, "t2b");

    // partial strobe
    wr("t3_full", BASE + 32'd4, 32'h1122_3344, 4'hF);
    take_b(0, "t3_full");
    wr("t3_part", BASE + 32'd4, 32'hAABB_CCDD, 4'b0101);
    take_b(0, "t3_part");
    check("t3_reg1", 64'(reg_o[1*DW +: DW]), 64'h11BB_33DD);

    // out of range above, below, and the last register; low address bits ignored
    snap = reg_o;
    wr("t4_wr", BASE + 32'(4 * NR), 32'hFFFF_FFFF, 4'hF);
    take_b(0, "t4_wr");
    check("t4_unchanged", 64'(reg_o === snap), 1);
    rd("t4_rd", BASE + 32'(4 * NR));
    take_r(0, "t4_rd");
    rd("t4_below", BASE - 32'd4);
    take_r(0, "t4_below");
    rd("t4_last", BASE + 32'(4 * NR - 4));
    take_r(0, "t4_last");
    rd("t4_lowbits", BASE + 32'd11);
    take_r(0, "t4_lowbits");

    // backpressure
    wr("t5_wr", BASE + 32'd24, 32'h0BAD_F00D, 4'hF);
    take_b(5, "t5_wr");
    rd("t5_rd", BASE + 32'd24);
    take_r(5, "t5_rd");

    // same-edge read and write of reg3: read returns the old value
    wr("t6_pre", BASE + 32'd12, 32'd5, 4'hF);
    take_b(0, "t6_pre");
    read_expect(BASE + 32'd12);
    write_expect(BASE + 32'd12, 32'd7, 4'hF);
    drive_req("t6_both", 1'b1, 1'b1, 1'b1, BASE + 32'd12, 32'd7, 4'hF, BASE + 32'd12);
    take_b(1, "t6_b");
    take_r(2, "t6_r");
    rd("t6_next", BASE + 32'd12);
    take_r(0, "t6_next");

    // randomised traffic against the model
    for (int i = 0; i < 12; i++) begin
      ra = BASE + 32'(4 * $urandom_range(0, NR)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = BASE - 32'(4 * $urandom_range(1, 4));
      wr("rnd_wr", ra, $urandom, 4'($urandom_range(0, 15)));
      take_b($urandom_range(0, 2), "rnd_wr");
      ra = BASE + 32'(4 * $urandom_range(0, NR));
      rd("rnd_rd", ra);
      take_r($urandom_range(0, 2), "rnd_rd");
    end
    check("final_reg_o", 64'(regs_mismatch()), 0);
    check("final_queues", 64'(b_exp_q.size() + r_exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
